rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two write-back requesters: req0 (ALU/execute) and req1 (load/memory unit).
- Uses a valid/ready handshake and round-robin arbitration.
- Registers the winning request into an output stage that drives the register file write port. The register file commits on the following negedge.
- Filters writes to r0 and counts arbitration conflicts for performance debug.

---
 rtl/rf_wb_arbiter_pkg.sv | 11 +
 rtl/rf_wb_arbiter_pick.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 98 +++++++++
 tb/tb_rf_wb_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and requester index type for the register file write-back arbiter.
package rf_wb_arbiter_pkg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_idx_e;
endpackage

// File: rtl/rf_wb_arbiter_pick.sv
// rfa_rr_pick: combinational 2-way picker, round-robin by default or fixed
// req1-first priority when RFA_FIXED_PRIO_EN is defined.
module rfa_rr_pick
   import rf_wb_arbiter_pkg::*;
(
   input  logic     v0,
   input  logic     v1,
   input  req_idx_e last,
   input  logic     hold,
   output logic     g0,
   output logic     g1
);

`ifdef RFA_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!hold) begin
         g1 = v1;
         g0 = v0 & ~v1;
      end
   end
`else
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!hold) begin
         // On a conflict the side that did not win last time goes first.
         if (v0 && v1) begin
            g0 = (last == REQ_MEM);
            g1 = (last == REQ_ALU);
         end else begin
            g0 = v0;
            g1 = v1;
         end
      end
   end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port (ALU vs. memory).
// Define RFA_FIXED_PRIO_EN for fixed memory-first priority instead of round-robin.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DW = rf_wb_arbiter_pkg::DW,
   parameter int AW = rf_wb_arbiter_pkg::AW,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold,
   input  logic          v0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] d0,
   output logic          rdy0,
   input  logic          v1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] d1,
   output logic          rdy1,
   output logic          rf_wr,
   output logic [AW-1:0] rf_a3,
   output logic [DW-1:0] rf_wd,
   output logic [CW-1:0] conflicts
);

   logic          g0, g1, frz, both;
   req_idx_e      last_q, last_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] a3_q, a3_d;
   logic [DW-1:0] wd_q, wd_d;
   logic [CW-1:0] conf_q, conf_d;

   // Reset blocks grants so nothing is accepted that the output stage would drop.
   assign frz  = hold | rst;
   assign both = v0 & v1 & ~frz;

   rfa_rr_pick u_pick (
      .v0   (v0),
      .v1   (v1),
      .last (last_q),
      .hold (frz),
      .g0   (g0),
      .g1   (g1)
   );

   assign rdy0 = g0;
   assign rdy1 = g1;

   always_comb begin
      last_d = last_q;
`ifndef RFA_FIXED_PRIO_EN
      if (both) last_d = g0 ? REQ_ALU : REQ_MEM;
`endif
   end

   always_comb begin
      wr_d = 1'b0;
      a3_d = a3_q;
      wd_d = wd_q;
      if (g0) begin
         a3_d = a0;
         wd_d = d0;
         wr_d = (a0 != AW'(REG_ZERO));
      end else if (g1) begin
         a3_d = a1;
         wd_d = d1;
         wr_d = (a1 != AW'(REG_ZERO));
      end
   end

   always_comb begin
      conf_d = conf_q;
      if (both && (conf_q != {CW{1'b1}})) conf_d = conf_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= REQ_MEM;
         wr_q   <= 1'b0;
         a3_q   <= '0;
         wd_q   <= '0;
         conf_q <= '0;
      end else begin
         last_q <= last_d;
         wr_q   <= wr_d;
         a3_q   <= a3_d;
         wd_q   <= wd_d;
         conf_q <= conf_d;
      end
   end

   assign rf_wr     = wr_q;
   assign rf_a3     = a3_q;
   assign rf_wd     = wd_q;
   assign conflicts = conf_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes are queued at grant time and
// a negedge monitor pops and compares each register file write.
module tb_rf_wb_arbiter;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hold = 1'b0;
   logic          v0 = 1'b0, v1 = 1'b0;
   logic [4:0]    a0 = '0, a1 = '0;
   logic [31:0]   d0 = '0, d1 = '0;
   logic          rdy0, rdy1, rf_wr;
   logic [4:0]    rf_a3;
   logic [31:0]   rf_wd;
   logic [CW-1:0] conflicts;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t         sbq[$];
   logic [31:0] rfm[32];

   rf_wb_arbiter #(.DW(32), .AW(5), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .v0        (v0),
      .a0        (a0),
      .d0        (d0),
      .rdy0      (rdy0),
      .v1        (v1),
      .a1        (a1),
      .d1        (d1),
      .rdy1      (rdy1),
      .rf_wr     (rf_wr),
      .rf_a3     (rf_a3),
      .rf_wd     (rf_wd),
      .conflicts (conflicts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Register file model commits on the negedge; scoreboard check rides along.
   always @(negedge clk) begin
      wr_t e;
      if (rf_wr === 1'b1) begin
         rfm[rf_a3] = rf_wd;
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got a3=%0d wd=%0h expected no write", rf_a3, rf_wd);
         end else begin
            e = sbq.pop_front();
            chk("wb_addr", 32'(rf_a3), 32'(e.a));
            chk("wb_data", rf_wd, e.d);
         end
      end
   end

   // Drive one cycle; e0/e1 are the hand-derived expected grants.
   task automatic step(input logic r, input logic h,
                       input logic vv0, input logic [4:0] aa0, input logic [31:0] dd0,
                       input logic vv1, input logic [4:0] aa1, input logic [31:0] dd1,
                       input logic e0, input logic e1);
      wr_t w;
      rst = r; hold = h;
      v0 = vv0; a0 = aa0; d0 = dd0;
      v1 = vv1; a1 = aa1; d1 = dd1;
      @(negedge clk);
      chk("rdy0", 32'(rdy0), 32'(e0));
      chk("rdy1", 32'(rdy1), 32'(e1));
      if (e0 && aa0 != 5'd0) begin w.a = aa0; w.d = dd0; sbq.push_back(w); end
      if (e1 && aa1 != 5'd0) begin w.a = aa1; w.d = dd1; sbq.push_back(w); end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      // reset with a request presented: no grant allowed
      step(1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      chk("rst_wr", 32'(rf_wr), 32'd0);
      chk("rst_a3", 32'(rf_a3), 32'd0);
      chk("rst_wd", rf_wd, 32'd0);
      chk("rst_conf", 32'(conflicts), 32'd0);

      // single ALU write, one-cycle latency
      step(1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      chk("t1_wr", 32'(rf_wr), 32'd1);
      chk("t1_a3", 32'(rf_a3), 32'd3);
      chk("t1_wd", rf_wd, 32'h1234);
      idle();
      chk("t1_wr_off", 32'(rf_wr), 32'd0);

      // sustained conflict alternates starting with req0
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, (i % 2) == 0, (i % 2) == 1);
      idle();
      chk("t2_conf", 32'(conflicts), 32'd4);

      // write to r0 is accepted and discarded
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b1);
      chk("t3_r0_wr", 32'(rf_wr), 32'd0);

      // same destination: req0 first, req1 last and final
      step(1'b0, 1'b0, 1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hBB, 1'b0, 1'b1);
      idle();
      idle();
      chk("t4_reg5", rfm[5], 32'hBB);
      chk("t4_conf", 32'(conflicts), 32'd5);

      // hold freezes grants, counter and pointer (last=req0 before hold)
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
         chk("t5_hold_wr", 32'(rf_wr), 32'd0);
      end
      chk("t5_hold_conf", 32'(conflicts), 32'd5);
      step(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      idle();
      chk("t5_conf", 32'(conflicts), 32'd6);

      // reset right after a grant; pointer returns to favour req0
      step(1'b0, 1'b0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h11, 1'b0, 1'b0);
      chk("t6_rst_wr", 32'(rf_wr), 32'd0);
      chk("t6_rst_conf", 32'(conflicts), 32'd0);
      step(1'b0, 1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h13, 1'b0, 1'b1);
      chk("t6_conf", 32'(conflicts), 32'd1);

      // counter saturates at all-ones (4-bit here), pointer last=req0
      for (int i = 0; i < 16; i++)
         step(1'b0, 1'b0, 1'b1, 5'd14, 32'hE0, 1'b1, 5'd15, 32'hF0, (i % 2) == 1, (i % 2) == 0);
      chk("t7_sat", 32'(conflicts), 32'hF);
      step(1'b0, 1'b0, 1'b1, 5'd14, 32'hE0, 1'b1, 5'd15, 32'hF0, 1'b0, 1'b1);
      idle();
      idle();
      chk("t7_sat_hold", 32'(conflicts), 32'hF);
      chk("sb_drained", sbq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
